// File: rtl/rt_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between NumReq OBI requesters.
// Grants are combinational and the fixed one-cycle read response is routed back to its issuer.
module rt_mem_arbiter #(
  parameter int NumReq = 3,
  parameter int AddrW  = 32,
  parameter int DataW  = 32,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  output logic [NumReq-1:0]        gnt_o,
  input  logic [NumReq*AddrW-1:0]  addr_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*DataW/8-1:0] be_i,
  input  logic [NumReq*DataW-1:0]  wdata_i,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [DataW-1:0]         rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [AddrW-1:0]         mem_addr_o,
  output logic [DataW/8-1:0]       mem_be_o,
  output logic [DataW-1:0]         mem_wdata_o,
  input  logic [DataW-1:0]         mem_rdata_i
);

  localparam int BeW = DataW / 8;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IdxW-1:0] rsp_idx_q, rsp_idx_d;
  logic            rsp_we_q, rsp_we_d;
  logic            win_vld;
  logic [IdxW-1:0] win_idx;
  logic            rsp_live;

  // Index arithmetic wraps at NumReq, not at 2^IdxW.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int off);
    logic [IdxW:0] sum;
    sum = {1'b0, base} + (IdxW+1)'(off);
    if (sum >= (IdxW+1)'(NumReq)) begin
      sum = sum - (IdxW+1)'(NumReq);
    end
    return sum[IdxW-1:0];
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int off = 0; off < NumReq; off++) begin
      if (!win_vld && !rst_i && req_i[wrap_add(ptr_q, off)]) begin
        win_vld = 1'b1;
        win_idx = wrap_add(ptr_q, off);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (win_vld) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    mem_req_o   = win_vld;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (win_vld) begin
      mem_we_o    = we_i[win_idx] & ~rst_i;
      mem_addr_o  = addr_i[int'(win_idx)*AddrW +: AddrW];
      mem_be_o    = be_i[int'(win_idx)*BeW +: BeW];
      mem_wdata_o = wdata_i[int'(win_idx)*DataW +: DataW];
    end
  end

  always_comb begin
    ptr_d       = win_vld ? wrap_add(win_idx, 1) : ptr_q;
    rsp_valid_d = win_vld;
    rsp_idx_d   = win_idx;
    rsp_we_d    = mem_we_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_we_q    <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // A response still registered when reset rises is dropped.
  assign rsp_live = rsp_valid_q & ~rst_i;

  always_comb begin
    rvalid_o = '0;
    if (rsp_live) begin
      rvalid_o[rsp_idx_q] = 1'b1;
    end
  end

  assign rdata_o = (rsp_live && !rsp_we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_rt_mem_arbiter.sv
// Scoreboard bench for rt_mem_arbiter: directed OBI traffic against a small SRAM model,
// expected grants and responses queued by stimulus and checked by an independent monitor.
module tb_rt_mem_arbiter;

  localparam int NumReq = 3;
  localparam int AddrW  = 32;
  localparam int DataW  = 32;

  logic                      clk_i = 1'b0;
  logic                      rst_i = 1'b1;
  logic [NumReq-1:0]         req_i = '0;
  logic [NumReq-1:0]         gnt_o;
  logic [NumReq*AddrW-1:0]   addr_i = '0;
  logic [NumReq-1:0]         we_i = '0;
  logic [NumReq*DataW/8-1:0] be_i = '0;
  logic [NumReq*DataW-1:0]   wdata_i = '0;
  logic [NumReq-1:0]         rvalid_o;
  logic [DataW-1:0]          rdata_o;
  logic                      mem_req_o;
  logic                      mem_we_o;
  logic [AddrW-1:0]          mem_addr_o;
  logic [DataW/8-1:0]        mem_be_o;
  logic [DataW-1:0]          mem_wdata_o;
  logic [DataW-1:0]          memRdata;

  rt_mem_arbiter #(.NumReq(NumReq), .AddrW(AddrW), .DataW(DataW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (memRdata)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: byte-enabled writes, read data registered one cycle after the request.
  logic [31:0] sramMem [256];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) sramMem[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
      end else begin
        memRdata <= sramMem[mem_addr_o[9:2]];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [2:0]  gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
  } gntExp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  vld;
    logic [31:0] data;
  } rspExp_t;

  gntExp_t gntQ [256];
  rspExp_t rspQ [256];
  int gntWr = 0;
  int rspWr = 0;
  int cyc = 0;
  logic done = 1'b0;

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  task automatic setPort(input int i, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    req_i[i]            = r;
    we_i[i]             = w;
    addr_i[i*32 +: 32]  = a;
    be_i[i*4 +: 4]      = b;
    wdata_i[i*32 +: 32] = d;
  endtask

  // Queue this cycle's expected grant (and optionally its response next cycle), then advance.
  task automatic applyStimulus(input logic [2:0] g, input logic [31:0] a, input logic w,
                               input logic [3:0] b, input logic rspOn, input logic [31:0] rd);
    if (g != 3'b000) begin
      gntQ[gntWr] = '{cyc, g, a, w, b};
      gntWr++;
      if (rspOn) begin
        rspQ[rspWr] = '{cyc + 1, g, rd};
        rspWr++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleCycles(input int n);
    req_i = '0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic doReset(input int n);
    rst_i = 1'b1;
    req_i = '0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0;
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    // Requests during reset must not be granted.
    req_i = 3'b111;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_i = '0;

    // Single write then read via requester 1.
    setPort(1, 1'b1, 1'b1, 32'h100, 4'hF, 32'hA5A5_0001);
    applyStimulus(3'b010, 32'h100, 1'b1, 4'hF, 1'b1, 32'h0);
    setPort(1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    applyStimulus(3'b010, 32'h100, 1'b0, 4'hF, 1'b1, 32'hA5A5_0001);
    idleCycles(1);

    // Full contention from reset: order 0,1,2,0,1,2.
    doReset(2);
    setPort(0, 1'b1, 1'b1, 32'h200, 4'hF, 32'h1111_0000);
    setPort(1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    setPort(2, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    repeat (2) begin
      applyStimulus(3'b001, 32'h200, 1'b1, 4'hF, 1'b1, 32'h0);
      applyStimulus(3'b010, 32'h100, 1'b0, 4'hF, 1'b1, 32'hA5A5_0001);
      applyStimulus(3'b100, 32'h200, 1'b0, 4'hF, 1'b1, 32'h1111_0000);
    end
    idleCycles(1);

    // Pointer wrap: after granting 2, requester 0 beats 1.
    setPort(2, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    applyStimulus(3'b100, 32'h100, 1'b0, 4'hF, 1'b1, 32'hA5A5_0001);
    req_i[2] = 1'b0;
    setPort(0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    setPort(1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    applyStimulus(3'b001, 32'h200, 1'b0, 4'hF, 1'b1, 32'h1111_0000);
    req_i[0] = 1'b0;
    applyStimulus(3'b010, 32'h100, 1'b0, 4'hF, 1'b1, 32'hA5A5_0001);
    idleCycles(1);

    // Back-to-back: requester 1 fills 0x0..0xC, requester 2 streams them back.
    for (int k = 0; k < 4; k++) begin
      setPort(1, 1'b1, 1'b1, 32'(k*4), 4'hF, 32'h1010_1010 * 32'(k+1));
      applyStimulus(3'b010, 32'(k*4), 1'b1, 4'hF, 1'b1, 32'h0);
    end
    req_i = '0;
    for (int k = 0; k < 4; k++) begin
      setPort(2, 1'b1, 1'b0, 32'(k*4), 4'hF, 32'h0);
      applyStimulus(3'b100, 32'(k*4), 1'b0, 4'hF, 1'b1, 32'h1010_1010 * 32'(k+1));
    end
    idleCycles(1);

    // Reset the cycle after a read grant: the response is dropped and the pointer returns to 0.
    setPort(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    applyStimulus(3'b001, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0);
    doReset(1);
    setPort(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    setPort(1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
    applyStimulus(3'b001, 32'h4, 1'b0, 4'hF, 1'b1, 32'h2020_2020);
    req_i[0] = 1'b0;
    applyStimulus(3'b010, 32'h8, 1'b0, 4'hF, 1'b1, 32'h3030_3030);
    idleCycles(1);

    // Partial write with byte enables over a full word.
    setPort(0, 1'b1, 1'b1, 32'h300, 4'hF, 32'h1234_5678);
    applyStimulus(3'b001, 32'h300, 1'b1, 4'hF, 1'b1, 32'h0);
    setPort(0, 1'b1, 1'b1, 32'h300, 4'b0011, 32'hDEAD_BEEF);
    applyStimulus(3'b001, 32'h300, 1'b1, 4'b0011, 1'b1, 32'h0);
    setPort(0, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
    applyStimulus(3'b001, 32'h300, 1'b0, 4'hF, 1'b1, 32'h1234_BEEF);

    // Idle with busy payloads: memory outputs must stay zero.
    for (int i = 0; i < NumReq; i++) begin
      setPort(i, 1'b0, 1'b1, 32'hFFFF_0000, 4'hF, 32'h0000_CAFE);
    end
    idleCycles(3);
    done = 1'b1;
  end

  int checks = 0;
  int fails = 0;
  int gntRd = 0;
  int rspRd = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle either pops a due expectation or requires the idle values.
  initial begin
    forever begin
      @(negedge clk_i);
      if (gntRd < gntWr && gntQ[gntRd].cyc == cyc) begin
        checkOutput("gnt_o", 64'(gnt_o), 64'(gntQ[gntRd].gnt));
        checkOutput("mem_req_o", 64'(mem_req_o), 64'd1);
        checkOutput("mem_addr_o", 64'(mem_addr_o), 64'(gntQ[gntRd].addr));
        checkOutput("mem_we_o", 64'(mem_we_o), 64'(gntQ[gntRd].we));
        checkOutput("mem_be_o", 64'(mem_be_o), 64'(gntQ[gntRd].be));
        gntRd++;
      end else begin
        checkOutput("idle gnt_o", 64'(gnt_o), 64'd0);
        checkOutput("idle mem_req_o", 64'(mem_req_o), 64'd0);
        checkOutput("idle mem_we_o", 64'(mem_we_o), 64'd0);
        checkOutput("idle mem_addr_o", 64'(mem_addr_o), 64'd0);
        checkOutput("idle mem_be_o", 64'(mem_be_o), 64'd0);
        checkOutput("idle mem_wdata_o", 64'(mem_wdata_o), 64'd0);
      end
      if (rspRd < rspWr && rspQ[rspRd].cyc == cyc) begin
        checkOutput("rvalid_o", 64'(rvalid_o), 64'(rspQ[rspRd].vld));
        checkOutput("rdata_o", 64'(rdata_o), 64'(rspQ[rspRd].data));
        rspRd++;
      end else begin
        checkOutput("idle rvalid_o", 64'(rvalid_o), 64'd0);
        checkOutput("idle rdata_o", 64'(rdata_o), 64'd0);
      end
      if (done) begin
        checkOutput("grant queue drained", 64'(gntWr - gntRd), 64'd0);
        checkOutput("response queue drained", 64'(rspWr - rspRd), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
